// File: rtl/aud_dac_serializer.sv
// ---------------------------------------------------------------------------
// aud_dac_serializer
//   I2S transmitter running in the codec bit-clock domain. Accepts signed
//   playback samples over a valid/ready handshake, holds at most one sample
//   in reserve, and serializes each sample MSB-first into both the left and
//   right slots of one DACLRCK frame. Each slot has a one-bit delay after
//   the LRCK edge.
//
// Ports
//   i_clk         bit clock (codec BCLK); all logic on the rising edge
//   i_rst         synchronous active-high reset
//   i_en          playback enable
//   i_daclrck     codec DACLRCK (0 = left slot, 1 = right slot)
//   i_dac_data    DATA_W-bit sample from the DSP
//   i_dac_valid   i_dac_data is valid
//   o_dac_ready   holding register can accept a sample
//   o_aud_dacdat  serial DAC data
//   o_underrun    one-cycle pulse: a frame started with no sample available
// ---------------------------------------------------------------------------
module aud_dac_serializer #(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_daclrck,
    input  logic [DATA_W-1:0] i_dac_data,
    input  logic              i_dac_valid,
    output logic              o_dac_ready,
    output logic              o_aud_dacdat,
    output logic              o_underrun
);

    // Bit counter runs 0..DATA_W while bits go out and parks at DATA_W+1.
    localparam int              CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_BITS = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

    logic              lrck_q;
    logic              hold_full;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] frame_smp;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  cnt;
    logic              run;
    logic              dat_q;
    logic              und_q;

    logic              left_start;
    logic              right_start;
    logic              lr_edge;
    logic              xfer;
    logic              hold_ld;
    logic              hold_full_nxt;
    logic [DATA_W-1:0] frame_nxt;
    logic              und_nxt;

    assign left_start  = lrck_q & ~i_daclrck;
    assign right_start = ~lrck_q & i_daclrck;
    assign lr_edge     = left_start | right_start;

    assign o_dac_ready = i_en & ~hold_full;
    assign xfer        = i_dac_valid & o_dac_ready;
    // On a LEFT_START with an empty holder the incoming sample bypasses
    // straight into the frame register, so the holder is not loaded.
    assign hold_ld     = xfer & ~left_start;

    always_comb begin
        frame_nxt     = frame_smp;
        hold_full_nxt = hold_full;
        und_nxt       = 1'b0;
        if (left_start) begin
            if (i_en && hold_full) begin
                frame_nxt     = hold;
                hold_full_nxt = 1'b0;
            end else if (xfer) begin
                frame_nxt = i_dac_data;
            end else if (i_en) begin
                frame_nxt = '0;
                und_nxt   = 1'b1;
            end else begin
                // Disabled: play silence and drop any stale sample.
                frame_nxt     = '0;
                hold_full_nxt = 1'b0;
            end
        end else if (xfer) begin
            hold_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lrck_q    <= i_daclrck;
            hold_full <= 1'b0;
            hold      <= '0;
            frame_smp <= '0;
            shift     <= '0;
            cnt       <= CNT_SAT;
            run       <= 1'b0;
            dat_q     <= 1'b0;
            und_q     <= 1'b0;
        end else begin
            lrck_q    <= i_daclrck;
            hold_full <= hold_full_nxt;
            frame_smp <= frame_nxt;
            und_q     <= und_nxt;
            if (hold_ld)
                hold <= i_dac_data;
            if (left_start)
                run <= i_en;

            if (lr_edge) begin
                // Delay slot; a right slot replays frame_smp unchanged.
                cnt   <= '0;
                shift <= frame_nxt;
                dat_q <= 1'b0;
            end else begin
                dat_q <= run && (cnt < CNT_BITS) ? shift[DATA_W-1] : 1'b0;
                if (cnt < CNT_BITS)
                    shift <= shift << 1;
                if (cnt != CNT_SAT)
                    cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign o_aud_dacdat = dat_q;
    assign o_underrun   = und_q;

endmodule

// File: tb/tb_aud_dac_serializer.sv
// ---------------------------------------------------------------------------
// tb_aud_dac_serializer
//   Self-checking bench for aud_dac_serializer. A position-indexed reference
//   model (cycles since the last LRCK edge, indexing the slot's sample) is
//   compared against the DUT on every cycle; a table of frame vectors and a
//   few hand-written sequences check whole-slot words against constants.
// ---------------------------------------------------------------------------
module tb_aud_dac_serializer;

    localparam int W    = 16;
    localparam int IDLE = 999;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         lrck = 1'b1;
    logic [W-1:0] data = '0;
    logic         valid = 1'b0;
    logic         ready;
    logic         dat;
    logic         underrun;

    int checks = 0;
    int failures = 0;

    aud_dac_serializer #(.DATA_W(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_daclrck    (lrck),
        .i_dac_data   (data),
        .i_dac_valid  (valid),
        .o_dac_ready  (ready),
        .o_aud_dacdat (dat),
        .o_underrun   (underrun)
    );

    always #5 clk = ~clk;

    // upstream source
    logic [W-1:0] q[$];

    // reference model state
    logic         m_lrck = 1'b1;
    bit           m_hf = 0;
    logic [W-1:0] m_hold = '0;
    logic [W-1:0] m_frame = '0;
    logic [W-1:0] m_slot = '0;
    int           m_pos = IDLE;
    bit           m_run = 0;
    bit           m_und = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void update_src();
        valid = (q.size() > 0);
        data  = valid ? q[0] : W'($urandom);
    endfunction

    // One clock: model update at the edge, compare at the falling edge.
    task automatic cyc();
        bit rdy, xf, le, rs, exp_dat;
        xf = 0;
        @(posedge clk);
        if (rst) begin
            m_lrck = lrck; m_hf = 0; m_frame = '0; m_slot = '0;
            m_pos = IDLE; m_run = 0; m_und = 0;
        end else begin
            rdy = en && !m_hf;
            xf  = valid && rdy;
            le  = m_lrck && !lrck;
            rs  = !m_lrck && lrck;
            m_lrck = lrck;
            m_und  = 0;
            if (le) begin
                m_run = en;
                if (en && m_hf) begin
                    m_frame = m_hold; m_hf = 0;
                end else if (xf) begin
                    m_frame = data;
                end else if (en) begin
                    m_frame = '0; m_und = 1;
                end else begin
                    m_frame = '0; m_hf = 0;
                end
                m_slot = m_frame;
                m_pos  = 0;
            end else begin
                if (xf) begin
                    m_hold = data; m_hf = 1;
                end
                if (rs) begin
                    m_slot = m_frame;
                    m_pos  = 0;
                end else if (m_pos < IDLE) begin
                    m_pos++;
                end
            end
        end
        exp_dat = (m_run && m_pos >= 1 && m_pos <= W) ? m_slot[W-m_pos] : 1'b0;
        @(negedge clk);
        chk("model_dacdat", {31'd0, dat}, {31'd0, exp_dat});
        chk("model_underrun", {31'd0, underrun}, {31'd0, m_und});
        chk("model_ready", {31'd0, ready}, {31'd0, en && !m_hf});
        if (xf) void'(q.pop_front());
        update_src();
    endtask

    // Run one LRCK slot of 'half' clocks; capture the W bits after the delay
    // slot, count underrun pulses, and sample ready after edges E and E+1.
    task automatic slot(input bit lv, input int half, input int en_at, input int rst_at,
                        output logic [W-1:0] w, output int und, output bit r0, output bit r1);
        lrck = lv; w = '0; und = 0; r0 = 0; r1 = 0;
        for (int i = 0; i < half; i++) begin
            if (i == en_at) en = 1'b1;
            rst = (i == rst_at);
            cyc();
            if (i >= 1 && i <= W) w[W-i] = dat;
            und += int'(underrun);
            if (i == 0) r0 = ready;
            if (i == 1) r1 = ready;
        end
        rst = 1'b0;
    endtask

    typedef struct {
        string        nm;
        bit           en;
        bit           give;
        logic [W-1:0] smp;
        int           pre;
        int           half;
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_r;
        int           exp_und;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [W-1:0] lw, rw;
        int u, u2, half_r, ph;
        bit r0, r1;

        vt[0] = '{"basic",     1, 1, 16'hA5C3, 4, 32, 16'hA5C3, 16'hA5C3, 0};
        vt[1] = '{"underrun",  1, 0, 16'h0000, 4, 32, 16'h0000, 16'h0000, 1};
        vt[2] = '{"bypass",    1, 1, 16'h1234, 0, 32, 16'h1234, 16'h1234, 0};
        vt[3] = '{"ones",      1, 1, 16'hFFFF, 2, 32, 16'hFFFF, 16'hFFFF, 0};
        vt[4] = '{"disabled",  0, 1, 16'h5555, 2, 32, 16'h0000, 16'h0000, 0};
        vt[5] = '{"reenable",  1, 1, 16'h8001, 3, 32, 16'h8001, 16'h8001, 0};
        vt[6] = '{"short",     1, 1, 16'hF0F0, 3, 10, 16'hF080, 16'hF080, 0};

        // reset state
        update_src();
        cyc(); cyc();
        chk("rst_dacdat", {31'd0, dat}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        // frame vectors
        for (int k = 0; k < 7; k++) begin
            en = vt[k].en;
            if (vt[k].give) q.push_back(vt[k].smp);
            update_src();
            for (int i = 0; i < vt[k].pre; i++) cyc();
            slot(1'b0, vt[k].half, -1, -1, lw, u, r0, r1);
            slot(1'b1, vt[k].half, -1, -1, rw, u2, r0, r1);
            chk({vt[k].nm, "_left"}, {16'd0, lw}, {16'd0, vt[k].exp_l});
            chk({vt[k].nm, "_right"}, {16'd0, rw}, {16'd0, vt[k].exp_r});
            chk({vt[k].nm, "_underrun"}, u + u2, vt[k].exp_und);
            q.delete();
            update_src();
        end

        // back-pressure
        en = 1'b1;
        q.push_back(16'h1111); q.push_back(16'h2222); update_src();
        cyc();
        chk("bp_ready_full", {31'd0, ready}, 32'd0);
        cyc();
        slot(1'b0, 32, -1, -1, lw, u, r0, r1);
        chk("bp_ready_after_left", {31'd0, r0}, 32'd1);
        chk("bp_ready_after_accept", {31'd0, r1}, 32'd0);
        chk("bp_left1", {16'd0, lw}, 32'h1111);
        slot(1'b1, 32, -1, -1, rw, u, r0, r1);
        chk("bp_right1", {16'd0, rw}, 32'h1111);
        slot(1'b0, 32, -1, -1, lw, u, r0, r1);
        chk("bp_left2", {16'd0, lw}, 32'h2222);
        chk("bp_underrun", u, 0);
        slot(1'b1, 32, -1, -1, rw, u, r0, r1);
        chk("bp_right2", {16'd0, rw}, 32'h2222);

        // enable gating: held sample discarded, mid-frame re-enable is silent
        q.push_back(16'h3333); update_src();
        cyc(); cyc();
        en = 1'b0;
        chk("gate_ready_off", {31'd0, ready}, 32'd0);
        slot(1'b0, 32, 8, -1, lw, u, r0, r1);
        chk("gate_left", {16'd0, lw}, 32'h0);
        chk("gate_no_underrun", u, 0);
        chk("gate_ready_at_edge", {31'd0, r0}, 32'd0);
        chk("gate_ready_reenabled", {31'd0, ready}, 32'd1);
        slot(1'b1, 32, -1, -1, rw, u, r0, r1);
        chk("gate_right", {16'd0, rw}, 32'h0);
        slot(1'b0, 32, -1, -1, lw, u, r0, r1);
        chk("gate_discarded", {16'd0, lw}, 32'h0);
        chk("gate_next_underrun", u, 1);
        slot(1'b1, 32, -1, -1, rw, u, r0, r1);

        // reset at bit 7 of 16'hFFFF, with a second sample in the holder
        q.push_back(16'hFFFF); q.push_back(16'h7777); update_src();
        cyc(); cyc();
        slot(1'b0, 32, -1, 9, lw, u, r0, r1);
        chk("rstmid_left", {16'd0, lw}, 32'hFF00);
        chk("rstmid_hold_cleared", {31'd0, ready}, 32'd1);
        slot(1'b1, 32, -1, -1, rw, u, r0, r1);
        chk("rstmid_right", {16'd0, rw}, 32'h0);
        slot(1'b0, 32, -1, -1, lw, u, r0, r1);
        chk("rstmid_next_left", {16'd0, lw}, 32'h0);
        chk("rstmid_next_underrun", u, 1);
        slot(1'b1, 32, -1, -1, rw, u, r0, r1);

        // randomized run against the model
        half_r = 32; ph = 0;
        for (int i = 0; i < 4000; i++) begin
            if (++ph >= half_r) begin
                lrck = ~lrck; ph = 0;
                half_r = $urandom_range(8, 40);
            end
            if (q.size() < 2 && $urandom_range(0, 7) == 0) q.push_back(W'($urandom));
            if ($urandom_range(0, 63) == 0) en = ~en;
            rst = ($urandom_range(0, 499) == 0);
            update_src();
            cyc();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
